// File: rtl/pio_pkg.sv
// Shared constants and types for the pulse-capable output PIO.
package pio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_SET       = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_CLEAR     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PULSE     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN    = 3'd6;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;

    typedef enum logic {
        TMR_IDLE   = 1'b0,
        TMR_ACTIVE = 1'b1
    } tmr_state_t;

endpackage

// File: rtl/pio_out_pulse_if.sv
// Zero-wait-state Avalon-MM slave port of the output PIO.
interface pio_out_pulse_if;
    import pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_pulse_timer.sv
// One-shot down-counter: loads on a valid PULSE write, strobes expire on its last cycle.
module pio_pulse_timer
    import pio_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             expire_c
);

    tmr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A load always restarts the count, so it pre-empts expiry in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        expire_c = 1'b0;
        case (state_q)
            TMR_IDLE: begin
                if (load) begin
                    state_d = TMR_ACTIVE;
                    cnt_d   = len;
                end
            end
            TMR_ACTIVE: begin
                if (load) begin
                    cnt_d = len;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d  = TMR_IDLE;
                    cnt_d    = '0;
                    expire_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    assign busy = (state_q == TMR_ACTIVE);

endmodule

// File: rtl/pio_out_pulse.sv
// Output PIO with DATA/SET/CLEAR access and a shared auto-clearing pulse on selected bits.
module pio_out_pulse
    import pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_out_pulse_if.slave   bus,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] pulse_mask_q;
    logic [CNT_W-1:0] pulse_len_q;
    logic             done_q;
    logic             irq_en_q;

    logic             wr_c;
    logic [WIDTH-1:0] wr_bits;
    logic [CNT_W-1:0] wr_len;
    logic             pulse_load_c;
    logic             busy;
    logic             expire_c;
    logic [BUS_W-1:0] readdata_c;
    logic             unused_wdata;

    assign wr_c         = bus.chipselect && !bus.write_n;
    assign wr_bits      = bus.writedata[WIDTH-1:0];
    assign wr_len       = bus.writedata[CNT_W-1:0];
    assign unused_wdata = ^bus.writedata;

    // A PULSE write with an empty mask or zero length is dropped entirely.
    assign pulse_load_c = wr_c && (bus.address == ADDR_PULSE)
                          && (wr_bits != '0) && (pulse_len_q != '0);

    pio_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (pulse_load_c),
        .len      (pulse_len_q),
        .busy     (busy),
        .expire_c (expire_c)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q       <= RESET_VALUE;
            pulse_mask_q <= '0;
            pulse_len_q  <= '0;
            done_q       <= 1'b0;
            irq_en_q     <= 1'b0;
        end else begin
            if (wr_c) begin
                case (bus.address)
                    ADDR_DATA:      data_q      <= wr_bits;
                    ADDR_SET:       data_q      <= data_q | wr_bits;
                    ADDR_CLEAR:     data_q      <= data_q & ~wr_bits;
                    ADDR_PULSE_LEN: pulse_len_q <= wr_len;
                    ADDR_IRQ_EN:    irq_en_q    <= bus.writedata[0];
                    default: ;
                endcase
            end

            if (pulse_load_c) begin
                pulse_mask_q <= pulse_mask_q | wr_bits;
            end else if (expire_c) begin
                pulse_mask_q <= '0;
            end

            // Expiry beats a simultaneous write-one-to-clear.
            if (expire_c) begin
                done_q <= 1'b1;
            end else if (wr_c && (bus.address == ADDR_STATUS) && bus.writedata[ST_DONE]) begin
                done_q <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata_c = '0;
        case (bus.address)
            ADDR_DATA:      readdata_c = BUS_W'(data_q);
            ADDR_PULSE_LEN: readdata_c = BUS_W'(pulse_len_q);
            ADDR_PULSE:     readdata_c = BUS_W'(pulse_mask_q);
            ADDR_STATUS: begin
                readdata_c[ST_BUSY] = busy;
                readdata_c[ST_DONE] = done_q;
            end
            ADDR_IRQ_EN:    readdata_c[0] = irq_en_q;
            default: ;
        endcase
    end

    assign bus.readdata = readdata_c;
    assign out_port     = data_q | pulse_mask_q;
    assign irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed and random bench for pio_out_pulse against a remaining-cycles reference model.
module tb_pio_out_pulse;
    import pio_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 16;
    localparam logic [7:0]  RV    = 8'hA5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] out_port;
    logic             irq;

    pio_out_pulse_if bus ();

    pio_out_pulse #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .RESET_VALUE (RV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: pulse tracked as "cycles of high output remaining".
    logic [7:0]  m_data  = RV;
    logic [7:0]  m_mask  = '0;
    logic [15:0] m_len   = '0;
    int          m_rem   = 0;
    logic        m_done  = 1'b0;
    logic        m_ien   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd3:    return 32'(m_len);
            3'd4:    return 32'(m_mask);
            3'd5:    return {30'd0, m_done, (m_rem != 0)};
            3'd6:    return {31'd0, m_ien};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_apply(input logic rst, input logic cs, input logic wn,
                               input logic [2:0] a, input logic [31:0] d);
        logic       wr;
        logic       fire;
        logic       done_set;
        logic [7:0] m;
        if (!rst) begin
            m_data = RV; m_mask = '0; m_len = '0; m_rem = 0; m_done = 1'b0; m_ien = 1'b0;
            return;
        end
        wr       = cs && !wn;
        m        = d[7:0];
        fire     = wr && (a == 3'd4) && (m != 8'd0) && (m_len != 16'd0);
        done_set = 1'b0;
        if (fire) begin
            m_mask = m_mask | m;
            m_rem  = int'(m_len);
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_mask   = '0;
                done_set = 1'b1;
            end
        end
        if (done_set) m_done = 1'b1;
        else if (wr && (a == 3'd5) && d[1]) m_done = 1'b0;
        if (wr) begin
            case (a)
                3'd0: m_data = m;
                3'd1: m_data = m_data | m;
                3'd2: m_data = m_data & ~m;
                3'd3: m_len  = d[15:0];
                3'd6: m_ien  = d[0];
                default: ;
            endcase
        end
    endtask

    // One clock: drive at negedge, check readdata for reads, advance model, check outputs.
    task automatic do_cycle(input logic rst, input logic cs, input logic wn,
                            input logic [2:0] a, input logic [31:0] d);
        reset_n       = rst;
        bus.chipselect = cs;
        bus.write_n   = wn;
        bus.address   = a;
        bus.writedata = d;
        #1;
        if (cs && wn) chk("readdata", bus.readdata, model_read(a));
        @(posedge clk);
        model_apply(rst, cs, wn, a, d);
        @(negedge clk);
        chk("out_port", 32'(out_port), 32'(m_data | m_mask));
        chk("irq", 32'(irq), 32'(m_done & m_ien));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        do_cycle(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        do_cycle(1'b1, 1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic idle();
        do_cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = '0;
        bus.writedata  = '0;
        @(negedge clk);

        // Reset
        repeat (3) do_cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("rst_out", 32'(out_port), 32'h0000_00A5);
        chk("rst_irq", 32'(irq), 32'd0);
        for (int a = 3; a <= 6; a++) rd(3'(a));

        // SET / CLEAR
        wr(3'd0, 32'h00);
        wr(3'd1, 32'h81);
        wr(3'd2, 32'h01);
        chk("setclr_out", 32'(out_port), 32'h80);
        rd(3'd0);
        chk("data_rd", bus.readdata, 32'h80);
        rd(3'd1);
        rd(3'd2);
        chk("clear_rd", bus.readdata, 32'd0);

        // Pulse of length 4
        wr(3'd0, 32'h00);
        wr(3'd3, 32'd4);
        wr(3'd4, 32'h0F);
        chk("pulse_c0", 32'(out_port), 32'h0F);
        for (int i = 1; i < 4; i++) begin
            rd(3'd5);
            chk("pulse_hi", 32'(out_port), 32'h0F);
        end
        idle();
        chk("pulse_end", 32'(out_port), 32'h00);
        rd(3'd5);
        chk("pulse_done", bus.readdata, 32'h2);
        wr(3'd5, 32'h2);

        // Restart in the cycle the count reaches 1
        wr(3'd3, 32'd3);
        wr(3'd4, 32'h01);
        idle();
        idle();
        wr(3'd4, 32'h02);
        chk("restart_c0", 32'(out_port), 32'h03);
        for (int i = 1; i < 3; i++) begin
            rd(3'd5);
            chk("restart_busy", bus.readdata, 32'h1);
            chk("restart_hi", 32'(out_port), 32'h03);
        end
        rd(3'd5);
        chk("restart_done", bus.readdata, 32'h2);
        chk("restart_end", 32'(out_port), 32'h00);
        wr(3'd5, 32'h2);

        // Ignored pulses
        wr(3'd0, 32'h80);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'hFF);
        chk("ign_len0", 32'(out_port), 32'h80);
        rd(3'd5);
        chk("ign_len0_st", bus.readdata, 32'h0);
        wr(3'd3, 32'd2);
        wr(3'd4, 32'h00);
        chk("ign_mask0", 32'(out_port), 32'h80);
        rd(3'd5);
        chk("ign_mask0_st", bus.readdata, 32'h0);

        // IRQ
        wr(3'd6, 32'h1);
        wr(3'd4, 32'h01);
        idle();
        chk("irq_pre", 32'(irq), 32'd0);
        idle();
        chk("irq_set", 32'(irq), 32'd1);
        wr(3'd5, 32'h2);
        chk("irq_clr", 32'(irq), 32'd0);

        // Reset mid-pulse
        wr(3'd3, 32'd5);
        wr(3'd4, 32'h40);
        idle();
        do_cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("midrst_out", 32'(out_port), 32'h0000_00A5);
        rd(3'd5);
        chk("midrst_st", bus.readdata, 32'h0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic [2:0]  a;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd3) d = 32'($urandom_range(0, 6)) | (d & 32'hFFFF_0000);
            if (a == 3'd4 && $urandom_range(0, 5) == 0) d = d & 32'hFFFF_FF00;
            if (r < 2)       do_cycle(1'b0, 1'b0, 1'b1, a, d);
            else if (r < 45) wr(a, d);
            else if (r < 75) rd(a);
            else             idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
